su_fetch_seq: RTL and testbench

//  Instruction fetch/sequence controller for the MX11SU; sits directly upstream of the ISA decode ROM.

---
 rtl/su_fetch_seq.sv | 143 ++++++++++++++
 tb/tb_su_fetch_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/su_fetch_seq.sv
// MX11SU instruction fetch/sequence controller: fetches one opcode per instruction, holds it in insr,
// stalls on memory and LD/ST completion, takes interrupts only at instruction boundaries.
module su_fetch_seq #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned LSU_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [7:0] mem_data,
  input  logic       mem_rdy,
  output logic       mem_req,
  input  logic       lsu_done,
  input  logic       irq,
  output logic       irq_ack,
  output logic [7:0] insr,
  output logic       insr_le,
  output logic       fetch,
  output logic       intr,
  output logic       ce_n,
  output logic       halted,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_INTR,
    S_HALT
  } state_t;

  localparam logic [7:0] MEM_LAST = 8'(MEM_WAIT_MAX - 1);
  localparam logic [7:0] LSU_LAST = 8'(LSU_WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] insr_q, insr_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       irq_pend_q, irq_pend_d;
  logic       fault_q, fault_d;

  logic       fetch_q, intr_q, irq_ack_q, ce_n_q, halted_q, mem_req_q;

  logic       is_ldst;
  assign is_ldst = (insr_q[7:4] == 4'hB);

  always_comb begin
    state_d    = state_q;
    insr_d     = insr_q;
    wait_cnt_d = 8'd0;
    irq_pend_d = irq_pend_q | irq;
    fault_d    = fault_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end

      S_FETCH: begin
        if (mem_rdy) begin
          insr_d  = mem_data;
          state_d = S_EXEC;
        end else if (wait_cnt_q == MEM_LAST) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_EXEC: begin
        if (is_ldst && !lsu_done) begin
          if (wait_cnt_q == LSU_LAST) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end else if (irq_pend_q) begin
          state_d = S_INTR;
        end else if (insr_q == 8'hFF) begin
          state_d = S_HALT;
        end else if (!run) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_INTR: begin
        // A fresh irq arriving during the acknowledge cycle stays pending.
        irq_pend_d = irq;
        state_d    = run ? S_FETCH : S_IDLE;
      end

      S_HALT: begin
        if (!fault_q && irq_pend_q) state_d = S_INTR;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Decoder strobes are registered from the next state so they align with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      insr_q     <= 8'h00;
      wait_cnt_q <= 8'd0;
      irq_pend_q <= 1'b0;
      fault_q    <= 1'b0;
      fetch_q    <= 1'b0;
      intr_q     <= 1'b0;
      irq_ack_q  <= 1'b0;
      ce_n_q     <= 1'b1;
      halted_q   <= 1'b0;
      mem_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      insr_q     <= insr_d;
      wait_cnt_q <= wait_cnt_d;
      irq_pend_q <= irq_pend_d;
      fault_q    <= fault_d;
      fetch_q    <= (state_d == S_FETCH);
      intr_q     <= (state_d == S_INTR);
      irq_ack_q  <= (state_d == S_INTR);
      ce_n_q     <= (state_d == S_IDLE) || (state_d == S_HALT);
      halted_q   <= (state_d == S_HALT);
      mem_req_q  <= (state_d == S_FETCH);
    end
  end

  assign insr    = insr_q;
  assign insr_le = fetch_q & mem_rdy;
  assign fetch   = fetch_q;
  assign intr    = intr_q;
  assign irq_ack = irq_ack_q;
  assign ce_n    = ce_n_q;
  assign halted  = halted_q;
  assign mem_req = mem_req_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_su_fetch_seq.sv
// Bench for su_fetch_seq: directed scenarios then random traffic, every cycle compared
// against a behavioural model of the sequencing rules.
module tb_su_fetch_seq;
  localparam int MW = 15;
  localparam int LW = 7;

  logic       clk = 1'b0;
  logic       rst, run, mem_rdy, lsu_done, irq;
  logic [7:0] mem_data;
  logic       mem_req, irq_ack, insr_le, fetch, intr, ce_n, halted, fault;
  logic [7:0] insr;

  always #5 clk = ~clk;

  su_fetch_seq #(.MEM_WAIT_MAX(MW), .LSU_WAIT_MAX(LW)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_data(mem_data), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .lsu_done(lsu_done), .irq(irq), .irq_ack(irq_ack),
    .insr(insr), .insr_le(insr_le), .fetch(fetch), .intr(intr), .ce_n(ce_n),
    .halted(halted), .fault(fault)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_ack = 0;

  // Reference model: phase of the current instruction plus sticky bits.
  localparam int P_IDLE = 0, P_FETCH = 1, P_EXEC = 2, P_INTR = 3, P_HALT = 4;
  int         m_ph;
  int         m_waited;
  logic [7:0] m_insr;
  logic       m_pend, m_fault;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_waited = 0; m_insr = 8'h00; m_pend = 1'b0; m_fault = 1'b0;
  endtask

  // Advance the model by one clock given the inputs seen during that cycle.
  task automatic model_step(input logic r_rst, r_run, r_rdy, input logic [7:0] r_d,
                            input logic r_ld, r_irq);
    int  nxt;
    bit  pend_next;
    bit  busy;
    if (r_rst) begin
      model_reset();
      return;
    end
    nxt       = m_ph;
    pend_next = m_pend || r_irq;
    busy      = 0;
    if (m_ph == P_IDLE) begin
      if (r_run) nxt = P_FETCH;
    end else if (m_ph == P_FETCH) begin
      if (r_rdy) begin
        m_insr = r_d; nxt = P_EXEC;
      end else if (m_waited + 1 >= MW) begin
        m_fault = 1'b1; nxt = P_HALT;
      end else busy = 1;
    end else if (m_ph == P_EXEC) begin
      if (m_insr[7:4] == 4'hB && !r_ld) begin
        if (m_waited + 1 >= LW) begin
          m_fault = 1'b1; nxt = P_HALT;
        end else busy = 1;
      end else if (m_pend) nxt = P_INTR;
      else if (m_insr == 8'hFF) nxt = P_HALT;
      else nxt = r_run ? P_FETCH : P_IDLE;
    end else if (m_ph == P_INTR) begin
      pend_next = r_irq;
      nxt = r_run ? P_FETCH : P_IDLE;
    end else begin
      if (!m_fault && m_pend) nxt = P_INTR;
    end
    m_waited = busy ? m_waited + 1 : 0;
    m_pend   = pend_next;
    m_ph     = nxt;
  endtask

  // One clock: drive inputs, check outputs against the model, clock, update the model.
  task automatic cyc(input logic r_rst, r_run, r_rdy, input logic [7:0] r_d,
                     input logic r_ld, r_irq);
    bit active;
    rst = r_rst; run = r_run; mem_rdy = r_rdy; mem_data = r_d; lsu_done = r_ld; irq = r_irq;
    #1;
    active = (m_ph == P_FETCH) || (m_ph == P_EXEC) || (m_ph == P_INTR);
    chk1("fetch",   fetch,   m_ph == P_FETCH);
    chk1("mem_req", mem_req, m_ph == P_FETCH);
    chk1("intr",    intr,    m_ph == P_INTR);
    chk1("irq_ack", irq_ack, m_ph == P_INTR);
    chk1("ce_n",    ce_n,    !active);
    chk1("halted",  halted,  m_ph == P_HALT);
    chk1("fault",   fault,   m_fault);
    chk1("insr_le", insr_le, (m_ph == P_FETCH) && r_rdy);
    chk8("insr",    insr,    m_insr);
    if (irq_ack === 1'b1) n_ack++;
    if (insr_le === 1'b1) $display("t=%0t fetch byte=%h", $time, mem_data);
    @(posedge clk);
    model_step(r_rst, r_run, r_rdy, r_d, r_ld, r_irq);
    #1;
  endtask

  initial begin
    int a0;
    bit slow_mem;
    logic [7:0] d;
    rst = 1'b1; run = 1'b0; mem_rdy = 1'b0; mem_data = 8'h00; lsu_done = 1'b0; irq = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    cyc(1, 0, 0, 8'h00, 0, 0);

    // Back-to-back simple instructions
    cyc(0, 1, 1, 8'h00, 0, 0); cyc(0, 1, 1, 8'h00, 0, 0);
    cyc(0, 1, 1, 8'h85, 0, 0); cyc(0, 1, 1, 8'h85, 0, 0);
    cyc(0, 1, 1, 8'hE3, 0, 0); cyc(0, 1, 1, 8'hE3, 0, 0);
    chk8("t1_insr", insr, 8'hE3);
    cyc(0, 0, 1, 8'hE3, 0, 0);

    // LD with lsu_done on the fourth EXEC cycle
    cyc(0, 1, 1, 8'hB2, 0, 0); cyc(0, 1, 1, 8'hB2, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00, 0, 0);
    cyc(0, 1, 0, 8'h00, 1, 0);
    chk1("t2_fetch", fetch, 1'b1);
    cyc(0, 1, 1, 8'h00, 0, 0); cyc(0, 0, 0, 8'h00, 0, 0);

    // irq during LD wait is deferred to the boundary
    a0 = n_ack;
    cyc(0, 1, 1, 8'hB2, 0, 0); cyc(0, 1, 1, 8'hB2, 0, 0);
    cyc(0, 1, 0, 8'h00, 0, 0); cyc(0, 1, 0, 8'h00, 0, 1);
    cyc(0, 1, 0, 8'h00, 0, 0); cyc(0, 1, 0, 8'h00, 1, 0);
    cyc(0, 1, 0, 8'h00, 0, 0);
    cyc(0, 1, 1, 8'h00, 0, 0); cyc(0, 0, 0, 8'h00, 0, 0);
    chk8("t3_acks", 8'(n_ack - a0), 8'd1);

    // HALT opcode, then irq wake
    cyc(0, 1, 1, 8'hFF, 0, 0); cyc(0, 1, 1, 8'hFF, 0, 0); cyc(0, 1, 0, 8'h00, 0, 0);
    chk1("t4_halted", halted, 1'b1);
    cyc(0, 1, 0, 8'h00, 0, 0); cyc(0, 1, 0, 8'h00, 0, 1);
    cyc(0, 1, 0, 8'h00, 0, 0); cyc(0, 1, 0, 8'h00, 0, 0);
    cyc(0, 1, 1, 8'h00, 0, 0); cyc(0, 0, 0, 8'h00, 0, 0);

    // Memory timeout
    cyc(0, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < MW; i++) cyc(0, 1, 0, 8'h00, 0, 0);
    chk1("t5_fault", fault, 1'b1);
    cyc(0, 1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 8'h00, 0, 0);
    chk1("t5_still_halted", halted, 1'b1);
    cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 8'h00, 0, 0);

    // Reset during EXEC discards pending irq
    a0 = n_ack;
    cyc(0, 1, 1, 8'hB0, 0, 0); cyc(0, 1, 1, 8'hB0, 0, 0);
    cyc(0, 1, 0, 8'h00, 0, 1); cyc(1, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 8'h00, 0, 0);
    chk8("t6_acks", 8'(n_ack - a0), 8'd0);
    chk8("t6_insr", insr, 8'h00);

    // Random traffic
    slow_mem = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) slow_mem = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 9))
        0:       d = 8'hFF;
        1, 2, 3: d = {4'hB, 4'($urandom_range(0, 15))};
        default: d = 8'($urandom_range(0, 255));
      endcase
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
          slow_mem ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 3) != 0),
          d, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
